fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined RISC-V core. It owns the architectural fetch PC and issues in-order requests to instruction memory over a valid/ready port. It accepts redirects (taken branch/JAL/JALR target from the next-PC logic in execute) and delivers `{pc, instr}` pairs to the IF/ID boundary through a small elastic buffer. Responses in flight at a redirect are squashed by epoch tagging.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_if.sv | 34 +++
 rtl/fetch_fifo.sv | 52 +++++
 rtl/fetch_stage.sv | 126 ++++++++++++
 tb/tb_fetch_stage.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        epoch;
  } fetch_tag_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } fetch_state_t;
endpackage

// File: rtl/fetch_if.sv
// Redirect, instruction-memory and decode-side signals of the fetch stage.
// id_misalign exists only when FETCH_MISALIGN_CHK_EN is defined.
interface fetch_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        id_misalign;
`endif

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
    output imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr
`ifdef FETCH_MISALIGN_CHK_EN
    , output id_misalign
`endif
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
    input  imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr
`ifdef FETCH_MISALIGN_CHK_EN
    , input id_misalign
`endif
  );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with synchronous clear; push while full is accepted when a pop happens too.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   FULL_C  = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [AW:0]      r_cnt;
  logic             w_pop, w_push;

  assign w_pop   = i_pop && (r_cnt != '0);
  assign w_push  = i_push && ((r_cnt != FULL_C) || w_pop);
  assign o_rdata = r_mem[r_rd];
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PTR_ONE;
      if (w_pop)  r_rd <= r_rd + PTR_ONE;
      if (w_push && !w_pop)      r_cnt <= r_cnt + CNT_ONE;
      else if (!w_push && w_pop) r_cnt <= r_cnt - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_clear) r_mem[r_wr] <= i_wdata;
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC owner, credit-limited imem requests, epoch-squashed responses.
// Optional FETCH_MISALIGN_CHK_EN adds a trap state for misaligned redirect targets.
module fetch_stage import fetch_pkg::*; #(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input logic      clk,
  input logic      rst,
  fetch_if.master  bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int UW = CW + 1;
  localparam logic [UW-1:0] DEPTH_U = UW'(DEPTH);

  logic [31:0]   r_fetch_pc, r_req_addr;
  logic          r_epoch, r_req_epoch, r_pending, r_stale;
  logic [CW-1:0] w_inflight, w_outq_cnt;
  logic [UW-1:0] w_used;
  fetch_tag_t    w_tag_wr, w_tag_rd;
  fetch_entry_t  w_ent_wr, w_ent_rd;
  logic          w_tag_empty, w_out_empty;
  logic          w_redir, w_run, w_issue_ok, w_req_valid, w_accept;
  logic          w_rsp, w_out_push, w_out_pop;
  logic [31:0]   w_redir_pc;

  assign w_redir = bus.redirect_valid;
  assign w_used  = UW'(w_inflight) + UW'(w_outq_cnt);

  assign w_out_pop  = w_run && !w_out_empty && !w_redir && bus.id_ready;
  assign w_issue_ok = !rst && w_run && !w_redir &&
                      ((w_used < DEPTH_U) || ((w_used == DEPTH_U) && w_out_pop));
  // A raised-but-unaccepted request stays up, even across a redirect.
  assign w_req_valid = r_pending || w_issue_ok;
  assign w_accept    = w_req_valid && bus.imem_req_ready;

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_pending ? r_req_addr : r_fetch_pc;

  assign w_tag_wr   = '{pc: bus.imem_req_addr, epoch: (r_pending ? r_req_epoch : r_epoch)};
  assign w_rsp      = bus.imem_rsp_valid && !w_tag_empty;
  assign w_out_push = w_rsp && (w_tag_rd.epoch == r_epoch) && !w_redir;
  assign w_ent_wr   = '{pc: w_tag_rd.pc, instr: bus.imem_rsp_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc  <= RESET_PC;
      r_epoch     <= 1'b0;
      r_req_addr  <= RESET_PC;
      r_req_epoch <= 1'b0;
      r_pending   <= 1'b0;
      r_stale     <= 1'b0;
    end else begin
      if (w_redir) begin
        r_fetch_pc <= w_redir_pc;
        r_epoch    <= ~r_epoch;
      end else if (w_accept && !r_stale) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (w_issue_ok && !r_pending) begin
        r_req_addr  <= r_fetch_pc;
        r_req_epoch <= r_epoch;
      end
      r_pending <= w_req_valid && !bus.imem_req_ready;
      // Stale: a redirect moved fetch_pc while this request waited, so its acceptance must not advance it.
      r_stale   <= w_req_valid && !bus.imem_req_ready && (r_stale || w_redir);
    end
  end

  fetch_fifo #(.WIDTH($bits(fetch_tag_t)), .DEPTH(DEPTH)) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clear (1'b0),
    .i_push  (w_accept),
    .i_wdata (w_tag_wr),
    .i_pop   (w_rsp),
    .o_rdata (w_tag_rd),
    .o_empty (w_tag_empty),
    .o_count (w_inflight)
  );

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_out_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_redir),
    .i_push  (w_out_push),
    .i_wdata (w_ent_wr),
    .i_pop   (w_out_pop),
    .o_rdata (w_ent_rd),
    .o_empty (w_out_empty),
    .o_count (w_outq_cnt)
  );

`ifdef FETCH_MISALIGN_CHK_EN
  fetch_state_t r_state;
  logic [31:0]  r_trap_pc;
  logic         w_trap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_RUN;
      r_trap_pc <= '0;
    end else if (w_redir) begin
      r_trap_pc <= bus.redirect_pc;
      case (r_state)
        ST_RUN:  if (bus.redirect_pc[1:0] != 2'b00) r_state <= ST_TRAP;
        ST_TRAP: if (bus.redirect_pc[1:0] == 2'b00) r_state <= ST_RUN;
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign w_trap          = (r_state == ST_TRAP);
  assign w_run           = !w_trap;
  assign w_redir_pc      = bus.redirect_pc;
  assign bus.id_valid    = !w_redir && (w_trap || !w_out_empty);
  assign bus.id_pc       = w_trap ? r_trap_pc : (w_out_empty ? '0 : w_ent_rd.pc);
  assign bus.id_instr    = w_trap ? NOP_INSTR : (w_out_empty ? '0 : w_ent_rd.instr);
  assign bus.id_misalign = w_trap;
`else
  assign w_run        = 1'b1;
  assign w_redir_pc   = bus.redirect_pc & 32'hFFFF_FFFC;
  assign bus.id_valid = !w_redir && !w_out_empty;
  assign bus.id_pc    = w_out_empty ? '0 : w_ent_rd.pc;
  assign bus.id_instr = w_out_empty ? '0 : w_ent_rd.instr;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 1-cycle in-order instruction memory model.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  fetch_if fi();

  fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (fi.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory: request accepted at an edge answers in the following cycle.
  logic        acc_q = 1'b0;
  logic [31:0] acc_addr_q = '0;
  always @(negedge clk) begin
    fi.imem_rsp_valid = acc_q;
    fi.imem_rsp_data  = acc_q ? mem_data(acc_addr_q) : 32'h0;
    acc_q      = fi.imem_req_valid && fi.imem_req_ready;
    acc_addr_q = fi.imem_req_addr;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    tick();
    rst = 1'b1;
    fi.redirect_valid = 1'b0;
    fi.redirect_pc    = '0;
    fi.imem_req_ready = 1'b1;
    fi.id_ready       = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    fi.redirect_valid = 1'b0;
    fi.redirect_pc    = '0;
    fi.imem_req_ready = 1'b1;
    fi.id_ready       = 1'b1;
    fi.imem_rsp_valid = 1'b0;
    fi.imem_rsp_data  = '0;
    #2 rst = 1'b1;
    @(negedge clk);
    n_checks++; if (fi.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 0", fi.imem_req_valid); end
    n_checks++; if (fi.imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL reset_req_addr: got %h expected 00000000", fi.imem_req_addr); end
    n_checks++; if (fi.id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid: got %b expected 0", fi.id_valid); end
    n_checks++; if ({fi.id_pc, fi.id_instr} !== 64'h0) begin n_fail++; $display("FAIL reset_id_bus: got %h/%h expected 0/0", fi.id_pc, fi.id_instr); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (fi.imem_req_valid !== 1'b1 || fi.imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL first_req: got %b/%h expected 1/00000000", fi.imem_req_valid, fi.imem_req_addr); end
  endtask

  task automatic test_stream();
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_checks++; if (fi.imem_req_valid !== 1'b1 || fi.imem_req_addr !== 32'(4*k)) begin n_fail++; $display("FAIL stream_addr[%0d]: got %b/%h expected 1/%h", k, fi.imem_req_valid, fi.imem_req_addr, 32'(4*k)); end
      if (k >= 2) begin
        n_checks++; if (fi.id_valid !== 1'b1 || fi.id_pc !== 32'(4*(k-2)) || fi.id_instr !== mem_data(32'(4*(k-2)))) begin n_fail++; $display("FAIL stream_id[%0d]: got %b/%h/%h expected 1/%h/%h", k, fi.id_valid, fi.id_pc, fi.id_instr, 32'(4*(k-2)), mem_data(32'(4*(k-2)))); end
      end else begin
        n_checks++; if (fi.id_valid !== 1'b0) begin n_fail++; $display("FAIL stream_early_id[%0d]: got %b expected 0", k, fi.id_valid); end
      end
    end
  endtask

  task automatic test_backpressure();
    int accepted = 0;
    apply_reset();
    fi.id_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (fi.imem_req_valid && fi.imem_req_ready) accepted++;
    end
    n_checks++; if (accepted !== 2) begin n_fail++; $display("FAIL stall_accepts: got %0d expected 2", accepted); end
    n_checks++; if (fi.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL stall_req_low: got %b expected 0", fi.imem_req_valid); end
    n_checks++; if (fi.id_valid !== 1'b1 || fi.id_pc !== 32'h0) begin n_fail++; $display("FAIL stall_hold: got %b/%h expected 1/00000000", fi.id_valid, fi.id_pc); end
    tick();
    fi.id_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++; if (fi.id_valid !== 1'b1 || fi.id_pc !== 32'(4*k) || fi.imem_req_addr !== 32'(8+4*k)) begin n_fail++; $display("FAIL release[%0d]: got %b/%h addr %h expected 1/%h addr %h", k, fi.id_valid, fi.id_pc, fi.imem_req_addr, 32'(4*k), 32'(8+4*k)); end
    end
  endtask

  task automatic test_redirect_inflight();
    int bad = 0;
    apply_reset();
    repeat (4) @(negedge clk);
    tick();
    fi.redirect_valid = 1'b1;
    fi.redirect_pc    = 32'h0000_0100;
    @(negedge clk);
    n_checks++; if (fi.imem_req_valid !== 1'b0 || fi.id_valid !== 1'b0) begin n_fail++; $display("FAIL redirect_cycle: got req %b id %b expected 0/0", fi.imem_req_valid, fi.id_valid); end
    tick();
    fi.redirect_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (fi.id_valid && (fi.id_pc == 32'h8 || fi.id_pc == 32'hC)) bad++;
      n_checks++; if (fi.imem_req_addr !== 32'(32'h100 + 4*k)) begin n_fail++; $display("FAIL redir_addr[%0d]: got %h expected %h", k, fi.imem_req_addr, 32'(32'h100 + 4*k)); end
      if (k == 1) begin
        n_checks++; if (fi.id_valid !== 1'b0) begin n_fail++; $display("FAIL redir_early_id: got %b expected 0", fi.id_valid); end
      end
      if (k == 2) begin
        n_checks++; if (fi.id_valid !== 1'b1 || fi.id_pc !== 32'h100) begin n_fail++; $display("FAIL redir_first_id: got %b/%h expected 1/00000100", fi.id_valid, fi.id_pc); end
      end
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL squash_old_path: got %0d old-path deliveries expected 0", bad); end
  endtask

  task automatic test_redirect_pending();
    apply_reset();
    repeat (4) @(negedge clk);
    tick();
    fi.imem_req_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (fi.imem_req_valid !== 1'b1 || fi.imem_req_addr !== 32'h10) begin n_fail++; $display("FAIL pend_raise: got %b/%h expected 1/00000010", fi.imem_req_valid, fi.imem_req_addr); end
    tick();
    fi.redirect_valid = 1'b1;
    fi.redirect_pc    = 32'h0000_0200;
    @(negedge clk);
    n_checks++; if (fi.imem_req_valid !== 1'b1 || fi.imem_req_addr !== 32'h10 || fi.id_valid !== 1'b0) begin n_fail++; $display("FAIL pend_hold_redir: got %b/%h id %b expected 1/00000010 id 0", fi.imem_req_valid, fi.imem_req_addr, fi.id_valid); end
    tick();
    fi.redirect_valid = 1'b0;
    fi.imem_req_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (fi.imem_req_valid !== 1'b1 || fi.imem_req_addr !== 32'h10) begin n_fail++; $display("FAIL pend_complete: got %b/%h expected 1/00000010", fi.imem_req_valid, fi.imem_req_addr); end
    @(negedge clk);
    n_checks++; if (fi.imem_req_addr !== 32'h200) begin n_fail++; $display("FAIL pend_next_addr: got %h expected 00000200", fi.imem_req_addr); end
    @(negedge clk);
    n_checks++; if (fi.id_valid !== 1'b0 || fi.imem_req_addr !== 32'h204) begin n_fail++; $display("FAIL pend_drop: got id %b addr %h expected id 0 addr 00000204", fi.id_valid, fi.imem_req_addr); end
    @(negedge clk);
    n_checks++; if (fi.id_valid !== 1'b1 || fi.id_pc !== 32'h200 || fi.id_instr !== mem_data(32'h200)) begin n_fail++; $display("FAIL pend_new_id: got %b/%h/%h expected 1/00000200/%h", fi.id_valid, fi.id_pc, fi.id_instr, mem_data(32'h200)); end
  endtask

  task automatic test_wrap();
    apply_reset();
    fi.redirect_valid = 1'b1;
    fi.redirect_pc    = 32'hFFFF_FFFC;
    @(negedge clk);
    tick();
    fi.redirect_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (fi.imem_req_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_top: got %h expected fffffffc", fi.imem_req_addr); end
    @(negedge clk);
    n_checks++; if (fi.imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_zero: got %h expected 00000000", fi.imem_req_addr); end
    @(negedge clk);
    n_checks++; if (fi.id_valid !== 1'b1 || fi.id_pc !== 32'hFFFF_FFFC || fi.id_instr !== mem_data(32'hFFFF_FFFC)) begin n_fail++; $display("FAIL wrap_id_top: got %b/%h/%h expected 1/fffffffc/%h", fi.id_valid, fi.id_pc, fi.id_instr, mem_data(32'hFFFF_FFFC)); end
    @(negedge clk);
    n_checks++; if (fi.id_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_id_zero: got %h expected 00000000", fi.id_pc); end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    repeat (4) @(negedge clk);
    tick();
    rst = 1'b1;
    #1;
    n_checks++; if (fi.imem_req_valid !== 1'b0 || fi.id_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_outputs: got req %b id %b expected 0/0", fi.imem_req_valid, fi.id_valid); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (fi.imem_req_addr !== 32'h0 || fi.id_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_restart: got addr %h id %b expected 00000000/0", fi.imem_req_addr, fi.id_valid); end
    @(negedge clk);
    n_checks++; if (fi.id_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stale_rsp: got id_valid %b pc %h expected 0", fi.id_valid, fi.id_pc); end
    @(negedge clk);
    n_checks++; if (fi.id_valid !== 1'b1 || fi.id_pc !== 32'h0) begin n_fail++; $display("FAIL midrst_first_id: got %b/%h expected 1/00000000", fi.id_valid, fi.id_pc); end
  endtask

`ifdef FETCH_MISALIGN_CHK_EN
  task automatic test_misalign();
    apply_reset();
    fi.redirect_valid = 1'b1;
    fi.redirect_pc    = 32'h0000_0102;
    @(negedge clk);
    tick();
    fi.redirect_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++; if (fi.id_valid !== 1'b1 || fi.id_misalign !== 1'b1 || fi.id_pc !== 32'h102 || fi.id_instr !== 32'h13 || fi.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL trap_hold[%0d]: got v%b m%b %h %h req %b expected v1 m1 00000102 00000013 req 0", k, fi.id_valid, fi.id_misalign, fi.id_pc, fi.id_instr, fi.imem_req_valid); end
      tick();
      fi.id_ready = k[0];
    end
    fi.id_ready       = 1'b1;
    fi.redirect_valid = 1'b1;
    fi.redirect_pc    = 32'h0000_0200;
    @(negedge clk);
    tick();
    fi.redirect_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (fi.imem_req_valid !== 1'b1 || fi.imem_req_addr !== 32'h200 || fi.id_misalign !== 1'b0) begin n_fail++; $display("FAIL trap_resume: got %b/%h m%b expected 1/00000200 m0", fi.imem_req_valid, fi.imem_req_addr, fi.id_misalign); end
    repeat (2) @(negedge clk);
    n_checks++; if (fi.id_valid !== 1'b1 || fi.id_pc !== 32'h200 || fi.id_misalign !== 1'b0) begin n_fail++; $display("FAIL trap_resume_id: got %b/%h m%b expected 1/00000200 m0", fi.id_valid, fi.id_pc, fi.id_misalign); end
  endtask
`else
  task automatic test_misalign();
    apply_reset();
    fi.redirect_valid = 1'b1;
    fi.redirect_pc    = 32'h0000_0103;
    @(negedge clk);
    tick();
    fi.redirect_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (fi.imem_req_valid !== 1'b1 || fi.imem_req_addr !== 32'h100) begin n_fail++; $display("FAIL align_mask: got %b/%h expected 1/00000100", fi.imem_req_valid, fi.imem_req_addr); end
    repeat (2) @(negedge clk);
    n_checks++; if (fi.id_valid !== 1'b1 || fi.id_pc !== 32'h100) begin n_fail++; $display("FAIL align_mask_id: got %b/%h expected 1/00000100", fi.id_valid, fi.id_pc); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_pending();
    test_wrap();
    test_mid_reset();
    test_misalign();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end
endmodule
